// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM fade controller slice.
// Contents:
//   DUTY_W       - width of the PWM duty value (1/1024 units)
//   RATE_W       - width of the fade rate (PWM periods per step minus 1)
//   fade_state_e - fade controller states
package pwm_pkg;

  localparam int DUTY_W = 10;
  localparam int RATE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    FINISH = 2'd2
  } fade_state_e;

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running PWM period counter. It counts 0..TICK_LEN-1 and wraps, and it
// flags the last clock of each period so other PWM controllers can align to it.
// Ports:
//   clk         - clock
//   reset       - synchronous active-high reset, clears the counter
//   period_tick - high on the last clock of each PWM period
module pwm_period_timer #(
  parameter int TICK_LEN = 11
) (
  input  logic clk,
  input  logic reset,
  output logic period_tick
);

  localparam int CNT_W = (TICK_LEN > 1) ? $clog2(TICK_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_LEN - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Gated by reset so the tick stays low even for a degenerate TICK_LEN of 1.
  assign period_tick = !reset && (cnt_q == LAST);

endmodule

// File: rtl/pwm_fade_ctrl.sv
// PWM fade controller. Accepts a fade command (target duty, rate) and walks
// the registered duty one LSB at a time toward the target, only on PWM period
// boundaries, so the PWM generator sees each new duty from the start of a period.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   cmd_valid    - fade command present
//   cmd_ready    - command accepted when cmd_valid and cmd_ready are both high
//   cmd_target   - target duty (1/1024 units)
//   cmd_rate     - PWM periods per 1-LSB step minus 1
//   abort        - stop the active fade, holding the current duty
//   duty         - registered duty to the PWM generator
//   period_tick  - pulse on the last clock of each PWM period
//   busy         - high whenever a fade is in progress or finishing
//   done         - one-cycle pulse when a fade completes
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int PWM_FREQ = 5000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_target,
  input  logic [RATE_W-1:0] cmd_rate,
  input  logic              abort,
  output logic [DUTY_W-1:0] duty,
  output logic              period_tick,
  output logic              busy,
  output logic              done
);

  // Matches the PWM generator's period length in clocks.
  localparam int TICK_LEN = CLK_HZ / PWM_FREQ + 1;

  fade_state_e       state_q,    state_d;
  logic [DUTY_W-1:0] duty_q,     duty_d;
  logic [DUTY_W-1:0] target_q,   target_d;
  logic [RATE_W-1:0] rate_q,     rate_d;
  logic [RATE_W-1:0] rate_cnt_q, rate_cnt_d;

  pwm_period_timer #(
    .TICK_LEN (TICK_LEN)
  ) u_period_timer (
    .clk         (clk),
    .reset       (reset),
    .period_tick (period_tick)
  );

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    target_d   = target_q;
    rate_d     = rate_q;
    rate_cnt_d = rate_cnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          target_d   = cmd_target;
          rate_d     = cmd_rate;
          rate_cnt_d = '0;
          state_d    = (cmd_target == duty_q) ? FINISH : RAMP;
        end
      end

      RAMP: begin
        // Abort has priority over a step landing on the same tick.
        if (abort) begin
          state_d = IDLE;
        end else if (period_tick) begin
          if (rate_cnt_q == rate_q) begin
            rate_cnt_d = '0;
            // Stepping only toward an in-range target means duty cannot wrap.
            if (target_q > duty_q) begin
              duty_d = duty_q + 1'b1;
            end else if (target_q < duty_q) begin
              duty_d = duty_q - 1'b1;
            end
            if (duty_d == target_q) begin
              state_d = FINISH;
            end
          end else begin
            rate_cnt_d = rate_cnt_q + 1'b1;
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      duty_q     <= '0;
      target_q   <= '0;
      rate_q     <= '0;
      rate_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      target_q   <= target_d;
      rate_q     <= rate_d;
      rate_cnt_q <= rate_cnt_d;
    end
  end

  // Status outputs are forced low during reset, including its first cycle,
  // before the state register has been cleared.
  assign cmd_ready = !reset && (state_q == IDLE);
  assign busy      = !reset && (state_q != IDLE);
  assign done      = !reset && (state_q == FINISH);
  assign duty      = duty_q;

endmodule

// File: doc/pwm_fade_ctrl.md
PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter PWM_FREQ, default 5000, PWM frequency in Hz of the driven PWM_gen.
REQ-003 SHALL have port clk, input, 1, clock.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1, fade command present.
REQ-006 SHALL have port cmd_ready, output, 1, command accepted when cmd_valid and cmd_ready are both high.
REQ-007 SHALL have port cmd_target, input, 10, target duty in 1/1024 units.
REQ-008 SHALL have port cmd_rate, input, 8, PWM periods per 1-LSB step minus 1 (0 means step every period).
REQ-009 SHALL have port abort, input, 1, stop the active fade.
REQ-010 SHALL have port duty, output, 10, registered duty to PWM_gen.
REQ-011 SHALL have port period_tick, output, 1, one-cycle pulse on the last clock of each PWM period.
REQ-012 SHALL have port busy, output, 1, high when state is not IDLE.
REQ-013 SHALL have port done, output, 1, one-cycle pulse when a fade completes.

Function
REQ-014 SHALL use TICK_LEN = CLK_HZ/PWM_FREQ + 1 (integer division), equal to PWM_gen's period in clocks.
REQ-015 SHALL run a period counter 0..TICK_LEN-1 that wraps to 0; period_tick SHALL be high when the counter equals TICK_LEN-1.
REQ-016 SHALL implement states IDLE, RAMP and FINISH.
REQ-017 SHALL assert cmd_ready only in IDLE; cmd_valid in RAMP or FINISH SHALL be ignored and SHALL NOT be queued.
REQ-018 On accept, SHALL latch cmd_target and cmd_rate, and clear the rate counter.
REQ-019 If cmd_target equals duty, SHALL go to FINISH; otherwise SHALL go to RAMP.
REQ-020 In RAMP, on each period_tick: if the rate counter equals the latched rate, SHALL step duty by ±1 toward target and clear the rate counter; otherwise SHALL increment the rate counter.
REQ-021 Duty SHALL change only on period_tick cycles, so the new value is visible from the first clock of the next period.
REQ-022 When a step makes duty equal the target, SHALL go to FINISH.
REQ-023 FINISH SHALL last one cycle with done=1, then SHALL go to IDLE.
REQ-024 Duty SHALL never wrap; ±1 steps toward an in-range target SHALL keep 0..1023.
REQ-025 abort in RAMP SHALL go to IDLE next cycle, hold duty, and SHALL NOT pulse done.
REQ-026 abort on the same cycle as a period_tick step SHALL win: no step occurs.
REQ-027 abort in IDLE or FINISH SHALL be ignored.
REQ-028 The period counter SHALL free-run regardless of state.

Reset
REQ-029 While reset is high, duty, period counter, rate counter and latched target SHALL be 0, and state SHALL be IDLE.
REQ-030 While reset is high, period_tick, done, busy and cmd_ready SHALL be 0.
REQ-031 cmd_ready SHALL be 1 on the first cycle after reset falls.
REQ-032 Reset mid-fade SHALL abandon the fade, with no done pulse.

Structure
REQ-033 Package pwm_pkg SHALL hold DUTY_W=10, RATE_W=8 and the state enum.
REQ-034 The period counter SHALL be sub-module pwm_period_timer (parameter TICK_LEN, outputs period_tick), reusable to align other PWM controllers.

Verification (CLK_HZ=1000, PWM_FREQ=100 -> TICK_LEN=11)
REQ-035 Reset for 3 cycles then release -> duty=0, busy=0, cmd_ready=1 on first cycle after release; period_tick first at cycle 10 after release, then every 11 cycles.
REQ-036 From duty=0, accept target=4, rate=0 -> duty 1,2,3,4 after 4 consecutive ticks; done pulses the cycle after duty becomes 4; cmd_ready=1 the cycle after done.
REQ-037 From duty=0, accept target=2, rate=2 -> duty steps on the 3rd and 6th ticks after accept; no change on other ticks; one done pulse.
REQ-038 From duty=1023, accept target=1020, rate=0 -> duty 1022,1021,1020 on 3 ticks; no wrap; done once.
REQ-039 During a 0->100 fade, assert abort on the cycle of the 5th tick -> duty stays 4, busy=0 next cycle, no done; cmd_valid pulsed mid-fade is not accepted.
REQ-040 With duty=7, accept target=7 -> done=1 exactly one cycle after accept, no duty change, busy high for that one cycle only.
